// File: rtl/sprite_compositor_if.sv
// Pixel-side bundle between the sprite blocks, the compositor and the VGA stage.
// Latency: none (wires only).
// Backpressure: none; the pixel stream is free-running.
interface sprite_compositor_if #(
  parameter int NUM_OBJ = 4
);
  logic                       frame_start;
  logic                       pixel_valid;
  logic [NUM_OBJ-1:0][7:0]    obj_color;
  logic [7:0]                 bg_color;
  logic                       count_clear;
  logic [7:0]                 out_color;
  logic                       out_valid;
  logic                       collision_pulse;
  logic [NUM_OBJ-1:0]         collision_mask;
  logic [7:0]                 collision_count;

  // Pixel source / collision consumer side.
  modport master (
    output frame_start, pixel_valid, obj_color, bg_color, count_clear,
    input  out_color, out_valid, collision_pulse, collision_mask, collision_count
  );

  // Compositor side.
  modport slave (
    input  frame_start, pixel_valid, obj_color, bg_color, count_clear,
    output out_color, out_valid, collision_pulse, collision_mask, collision_count
  );
endinterface

// File: rtl/sprite_compositor.sv
// Priority compositor of sprite colours over background, plus per-frame player/obstacle overlap report.
// Latency: 2 clk from pixel in to out_color/out_valid; frame_start to collision outputs also 2 clk.
// Backpressure: none; one pixel per clk, never stalls.
module sprite_compositor #(
  parameter int          NUM_OBJ    = 4,
  parameter int          PLAYER_IDX = 0,
  parameter logic [7:0]  MASK_VALUE = 8'h62
) (
  input  logic               clk,
  input  logic               resetN,
  sprite_compositor_if.slave bus
);

  // Stage 1 registers
  logic [NUM_OBJ-1:0][7:0] r_s1_obj;
  logic [7:0]              r_s1_bg;
  logic                    r_s1_vld;
  logic                    r_s1_fs;
  logic [NUM_OBJ-1:0]      r_s1_opq;

  // Stage 2 / output registers
  logic [7:0]              r_out_color;
  logic                    r_out_valid;
  logic                    r_pulse;
  logic [NUM_OBJ-1:0]      r_mask;
  logic [7:0]              r_count;
  logic [NUM_OBJ-1:0]      r_hit_acc;

  logic [NUM_OBJ-1:0]      w_opq;
  logic [7:0]              w_sel_color;
  logic [NUM_OBJ-1:0]      w_overlap;
  logic                    w_any_hit;

  // Transparency test on the raw sprite colours.
  always_comb begin
    w_opq = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      w_opq[i] = (bus.obj_color[i] != MASK_VALUE);
    end
  end

  // S1: capture the pixel and its opacity flags.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_s1_obj <= '0;
      r_s1_bg  <= '0;
      r_s1_vld <= 1'b0;
      r_s1_fs  <= 1'b0;
      r_s1_opq <= '0;
    end else begin
      r_s1_obj <= bus.obj_color;
      r_s1_bg  <= bus.bg_color;
      r_s1_vld <= bus.pixel_valid;
      r_s1_fs  <= bus.frame_start;
      r_s1_opq <= w_opq;
    end
  end

  // Priority select: scanning from the lowest priority upward lets the lowest opaque index win.
  always_comb begin
    w_sel_color = r_s1_bg;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (r_s1_opq[i]) begin
        w_sel_color = r_s1_obj[i];
      end
    end
  end

  // Overlap of the player with every other object on a valid pixel; player bit stays 0.
  always_comb begin
    w_overlap = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (i != PLAYER_IDX) begin
        w_overlap[i] = r_s1_vld && r_s1_opq[PLAYER_IDX] && r_s1_opq[i];
      end
    end
  end

  assign w_any_hit = |r_hit_acc;

  // S2 pixel output: blank colour outside the active area.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_out_color <= 8'h00;
      r_out_valid <= 1'b0;
    end else begin
      r_out_color <= r_s1_vld ? w_sel_color : 8'h00;
      r_out_valid <= r_s1_vld;
    end
  end

  // S2 collision accumulation; a frame boundary reports the closing frame and
  // reloads with the current pixel's overlap so it belongs to the new frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_hit_acc <= '0;
      r_mask    <= '0;
      r_pulse   <= 1'b0;
    end else if (r_s1_fs) begin
      r_mask    <= r_hit_acc;
      r_pulse   <= w_any_hit;
      r_hit_acc <= w_overlap;
    end else begin
      r_pulse   <= 1'b0;
      r_hit_acc <= r_hit_acc | w_overlap;
    end
  end

  // Collision frame counter: saturates at 255, clear has priority over increment.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count <= 8'h00;
    end else if (bus.count_clear) begin
      r_count <= 8'h00;
    end else if (r_s1_fs && w_any_hit && (r_count != 8'hff)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign bus.out_color       = r_out_color;
  assign bus.out_valid       = r_out_valid;
  assign bus.collision_pulse = r_pulse;
  assign bus.collision_mask  = r_mask;
  assign bus.collision_count = r_count;

endmodule
